// File: rtl/formula_chain_pkg.sv
// Shared constants and latency helpers for the nested isqrt chain pipeline.
package formula_chain_pkg;

  localparam int ISQRT_LAT   = 16;
  localparam int ISQRT_IN_W  = 32;
  localparam int ISQRT_OUT_W = 16;

  // End-to-end latency: N isqrt stages plus one adder register between each pair.
  function automatic int chain_latency(input int n);
    return n * ISQRT_LAT + (n - 1);
  endfunction

  // Depth that lines x[k] up with the y_vld of isqrt stage k-1.
  function automatic int delay_depth(input int k);
    return k * ISQRT_LAT + (k - 1);
  endfunction

endpackage

// File: rtl/formula_chain_isqrt.sv
// Pipelined 32-bit integer square root, one result bit per stage, latency ISQRT_LAT.
module formula_chain_isqrt
  import formula_chain_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_vld,
  input  logic [ISQRT_IN_W-1:0]  x,
  output logic                   y_vld,
  output logic [ISQRT_OUT_W-1:0] y
);

  localparam int S = ISQRT_OUT_W;

  logic                   vld_q  [S];
  logic [ISQRT_OUT_W-1:0] root_q [S];
  logic [ISQRT_IN_W-1:0]  x_q    [S-1];
  logic [17:0]            rem_q  [S-1];

  for (genvar i = 0; i < S; i++) begin : g_st
    logic                   vi;
    logic [ISQRT_IN_W-1:0]  xi;
    logic [17:0]            ri;
    logic [ISQRT_OUT_W-1:0] qi;
    logic [19:0]            rem_sh;
    logic [19:0]            trial;
    logic                   ge;
    logic [17:0]            rem_next;
    logic [ISQRT_OUT_W-1:0] root_next;

    if (i == 0) begin : g_head
      assign vi = x_vld;
      assign xi = x;
      assign ri = '0;
      assign qi = '0;
    end else begin : g_body
      assign vi = vld_q[i-1];
      assign xi = x_q[i-1];
      assign ri = rem_q[i-1];
      assign qi = root_q[i-1];
    end

    // Bring down the next two radicand bits, then try appending a 1 to the root.
    assign rem_sh    = {ri, 2'(xi >> (ISQRT_IN_W - 2 - 2 * i))};
    assign trial     = {2'b00, qi, 2'b01};
    assign ge        = (rem_sh >= trial);
    assign rem_next  = ge ? 18'(rem_sh - trial) : 18'(rem_sh);
    assign root_next = ISQRT_OUT_W'({qi, ge});

    always_ff @(posedge clk) begin
      if (rst) vld_q[i] <= 1'b0;
      else     vld_q[i] <= vi;
    end

    always_ff @(posedge clk) begin
      if (vi) root_q[i] <= root_next;
    end

    if (i < S - 1) begin : g_carry
      always_ff @(posedge clk) begin
        if (vi) begin
          x_q[i]   <= xi;
          rem_q[i] <= rem_next;
        end
      end
    end
  end

  assign y_vld = vld_q[S-1];
  assign y     = root_q[S-1];

endmodule

// File: rtl/vld_delay_line.sv
// Valid-gated shift register: the valid chain resets and always shifts,
// a data slot only loads when the slot upstream of it holds a valid entry.
module vld_delay_line #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic         vld_q  [DEPTH];
  logic [W-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld) data_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (vld_q[i-1]) data_q[i] <= data_q[i-1];
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/formula_chain_pipe.sv
// Nested square-root chain res = isqrt(x[N-1] + ... isqrt(x[1] + isqrt(x[0]))),
// one argument set per clock, fixed latency, with an in-flight occupancy counter.
module formula_chain_pipe
  import formula_chain_pkg::*;
#(
  parameter int N_ARGS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         arg_vld,
  input  logic [32*N_ARGS-1:0]                         args,
  output logic                                         res_vld,
  output logic [15:0]                                  res,
  output logic [$clog2(chain_latency(N_ARGS)+2)-1:0]   inflight,
  output logic                                         busy
);

  localparam int CW = $clog2(chain_latency(N_ARGS) + 2);

  logic                   x_vld_a [N_ARGS];
  logic [ISQRT_IN_W-1:0]  x_a     [N_ARGS];
  logic                   y_vld_a [N_ARGS];
  logic [ISQRT_OUT_W-1:0] y_a     [N_ARGS];

  for (genvar k = 0; k < N_ARGS; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign x_vld_a[0] = arg_vld;
      assign x_a[0]     = args[ISQRT_IN_W-1:0];
    end else begin : g_add
      logic                  d_vld;
      logic [ISQRT_IN_W-1:0] d_x;
      logic [ISQRT_IN_W:0]   sum_w;
      logic                  sum_vld_q;
      logic [ISQRT_IN_W-1:0] sum_q;
      logic                  take;

      vld_delay_line #(
        .W     (ISQRT_IN_W),
        .DEPTH (delay_depth(k))
      ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (arg_vld),
        .in_data  (args[ISQRT_IN_W*k +: ISQRT_IN_W]),
        .out_vld  (d_vld),
        .out_data (d_x)
      );

      assign take  = y_vld_a[k-1] & d_vld;
      assign sum_w = {1'b0, d_x} + {17'b0, y_a[k-1]};

      always_ff @(posedge clk) begin
        if (rst) sum_vld_q <= 1'b0;
        else     sum_vld_q <= take;
      end

      // Carry-out either wraps (drop bit 32) or clamps to all ones.
      always_ff @(posedge clk) begin
        if (take) sum_q <= (SATURATE && sum_w[ISQRT_IN_W]) ? '1 : sum_w[ISQRT_IN_W-1:0];
      end

      assign x_vld_a[k] = sum_vld_q;
      assign x_a[k]     = sum_q;
    end

    formula_chain_isqrt u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld_a[k]),
      .x     (x_a[k]),
      .y_vld (y_vld_a[k]),
      .y     (y_a[k])
    );
  end

  assign res_vld = y_vld_a[N_ARGS-1];
  assign res     = y_a[N_ARGS-1];

  // Occupancy is bounded by the latency, so the counter cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({arg_vld, res_vld})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

endmodule

// File: tb/tb_formula_chain_pipe.sv
// Bench for formula_chain_pipe: four builds (N=3 wrap, N=3 saturate, N=1, N=5) share one stimulus.
module tb_formula_chain_pipe;

  localparam int ND = 4;

  logic         clk;
  logic         rst;
  logic         arg_vld;
  logic [159:0] args;

  logic        rv0, rv1, rv2, rv3;
  logic [15:0] r0, r1, r2, r3;
  logic [5:0]  inf0, inf1;
  logic [4:0]  inf2;
  logic [6:0]  inf3;
  logic        b0, b1, b2, b3;

  logic        o_vld  [ND];
  logic [15:0] o_res  [ND];
  logic [7:0]  o_inf  [ND];
  logic        o_busy [ND];

  int n_of   [ND] = '{3, 3, 1, 5};
  bit sat_of [ND] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          idle_chk = 1'b0;
  int          due_q [ND][$];
  logic [15:0] exp_q [ND][$];
  logic [15:0] last_val [ND];
  bit          have_last [ND];

  formula_chain_pipe #(.N_ARGS(3), .SATURATE(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args[95:0]),
    .res_vld(rv0), .res(r0), .inflight(inf0), .busy(b0));
  formula_chain_pipe #(.N_ARGS(3), .SATURATE(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args[95:0]),
    .res_vld(rv1), .res(r1), .inflight(inf1), .busy(b1));
  formula_chain_pipe #(.N_ARGS(1), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args[31:0]),
    .res_vld(rv2), .res(r2), .inflight(inf2), .busy(b2));
  formula_chain_pipe #(.N_ARGS(5), .SATURATE(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args[159:0]),
    .res_vld(rv3), .res(r3), .inflight(inf3), .busy(b3));

  always_comb begin
    o_vld[0] = rv0; o_res[0] = r0; o_inf[0] = {2'b0, inf0}; o_busy[0] = b0;
    o_vld[1] = rv1; o_res[1] = r1; o_inf[1] = {2'b0, inf1}; o_busy[1] = b1;
    o_vld[2] = rv2; o_res[2] = r2; o_inf[2] = {3'b0, inf2}; o_busy[2] = b2;
    o_vld[3] = rv3; o_res[3] = r3; o_inf[3] = {1'b0, inf3}; o_busy[3] = b3;
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned isqrt_m(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0; hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [15:0] chain(input logic [159:0] a, input int n, input bit sat);
    longint unsigned v, s;
    v = isqrt_m(longint'(a[31:0]));
    for (int k = 1; k < n; k++) begin
      s = longint'(a[32*k +: 32]) + v;
      if (s > 64'hFFFF_FFFF) s = sat ? 64'hFFFF_FFFF : (s & 64'hFFFF_FFFF);
      v = isqrt_m(s);
    end
    return v[15:0];
  endfunction

  function automatic int lat_of(input int n);
    return n * 16 + n - 1;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(posedge clk) begin
    logic         cap_vld, cap_rst;
    logic [159:0] cap_args;
    bit           exp_v;
    cap_vld  = arg_vld;
    cap_rst  = rst;
    cap_args = args;
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (cap_rst) begin
        due_q[d].delete();
        exp_q[d].delete();
      end else begin
        while (due_q[d].size() > 0 && due_q[d][0] < cyc) begin
          void'(due_q[d].pop_front());
          void'(exp_q[d].pop_front());
        end
        if (cap_vld) begin
          due_q[d].push_back(cyc - 1 + lat_of(n_of[d]));
          exp_q[d].push_back(chain(cap_args, n_of[d], sat_of[d]));
        end
      end
      exp_v = (due_q[d].size() > 0) && (due_q[d][0] == cyc);
      check($sformatf("res_vld[%0d]", d), longint'(o_vld[d]), longint'(exp_v));
      check($sformatf("inflight[%0d]", d), longint'(o_inf[d]), longint'(due_q[d].size()));
      check($sformatf("busy[%0d]", d), longint'(o_busy[d]), longint'(due_q[d].size() != 0));
      if (exp_v) begin
        check($sformatf("res[%0d]", d), longint'(o_res[d]), longint'(exp_q[d][0]));
        last_val[d]  = exp_q[d][0];
        have_last[d] = 1'b1;
      end else if (idle_chk && have_last[d]) begin
        check($sformatf("idle_hold[%0d]", d), longint'(o_res[d]), longint'(last_val[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [159:0] a, input logic r);
    @(negedge clk);
    arg_vld = v;
    args    = a;
    rst     = r;
  endtask

  function automatic logic [159:0] rand_args();
    logic [159:0] a;
    for (int k = 0; k < 5; k++) begin
      case ($urandom_range(0, 3))
        0:       a[32*k +: 32] = $urandom;
        1:       a[32*k +: 32] = 32'hFFFF_FFFF;
        2:       a[32*k +: 32] = $urandom_range(0, 1000);
        default: a[32*k +: 32] = 32'h0;
      endcase
    end
    return a;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  // Single set, then wait (bounded) for DUT d's result and pin latency and value.
  task automatic directed(input logic [159:0] a, input int d, input int exp_lat,
                          input logic [15:0] exp_res, input string nm);
    int          seen;
    logic [15:0] got;
    seen = 0;
    got  = '0;
    drive(1'b1, a, 1'b0);
    for (int i = 1; i <= exp_lat + 10 && seen == 0; i++) begin
      @(posedge clk);
      #2;
      if (i == 1) arg_vld = 1'b0;
      if (o_vld[d]) begin
        seen = i;
        got  = o_res[d];
      end
    end
    check({nm, "_latency"}, seen, exp_lat);
    check({nm, "_value"}, longint'(got), longint'(exp_res));
  endtask

  // ---------------- stimulus ----------------
  logic [159:0] vec_a, vec_b, vec_c;

  initial begin
    rst     = 1'b1;
    arg_vld = 1'b0;
    args    = '0;
    vec_a   = '0; vec_a[31:0] = 32'd16;
    vec_b   = '0; vec_b[31:0] = 32'hFFFF_FFFF; vec_b[63:32] = 32'hFFFF_FFFF;
    vec_c   = '0; vec_c[31:0] = 32'd81;

    // Pin the model against hand-worked chains.
    check("model_16_0_0", longint'(chain(vec_a, 3, 1'b0)), 1);
    check("model_wrap", longint'(chain(vec_b, 3, 1'b0)), 15);
    check("model_sat", longint'(chain(vec_b, 3, 1'b1)), 255);
    check("model_n1_81", longint'(chain(vec_c, 1, 1'b0)), 9);
    check("model_n5_81", longint'(chain(vec_c, 5, 1'b0)), 1);

    repeat (3) @(negedge clk);
    drive(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    check("reset_res_vld", longint'(rv0), 0);
    check("reset_inflight", longint'(inf0), 0);
    check("reset_busy", longint'(b0), 0);

    directed(vec_a, 0, 50, 16'd1, "n3_x16");
    directed(vec_b, 0, 50, 16'd15, "n3_wrap");
    directed(vec_b, 1, 50, 16'd255, "n3_sat");
    directed(vec_c, 2, 16, 16'd9, "n1_x81");
    idle(100);
    directed(vec_c, 3, 84, 16'd1, "n5_x81");
    idle(20);

    // Back-to-back: one set every cycle.
    for (int i = 0; i < 200; i++) drive(1'b1, rand_args(), 1'b0);
    idle(100);

    // Long idle window: outputs must hold the last result.
    @(negedge clk); idle_chk = 1'b1;
    idle(60);
    idle_chk = 1'b0;

    // Sparse valid, about 30% duty.
    for (int i = 0; i < 300; i++) drive(($urandom_range(0, 99) < 30), rand_args(), 1'b0);
    idle(100);

    // Reset mid-stream, with arg_vld also high in the reset cycle.
    for (int i = 0; i < 30; i++) drive((i < 10) || (i == 20), rand_args(), (i == 20));
    @(posedge clk); #2;
    check("post_reset_inflight", longint'(inf0), 0);
    idle(100);
    for (int i = 0; i < 5; i++) drive(1'b1, rand_args(), 1'b0);
    idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
